pixel_scheduler: RTL and testbench

- Frame-level scheduler that shares the screen's pixels between NUM_ENGINES mandelbrot_engine instances.
- Scans the frame in raster order and hands each (x0_, y0_) to one ready engine, using round-robin arbitration.
- Latches the view configuration (zoom, offsets) at frame start and holds it stable for all engines.
- Signals frame completion once every engine has gone idle after the last pixel.

---
 rtl/pixel_scheduler.sv | 158 +++++++++++++++
 tb/tb_pixel_scheduler.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_scheduler.sv
// rtl/pixel_scheduler.sv - raster-order round-robin pixel dispatcher for mandelbrot engines
// Optional build macro: CONTINUOUS_FRAME_EN (restart the next frame from DONE without start)
module pixel_scheduler #(
    parameter int NUM_ENGINES       = 4,
    parameter int PIXEL_DATA_WIDTH  = 10,
    parameter int ENGINE_DATA_WIDTH = 25,
    parameter int SCREEN_WIDTH      = 640,
    parameter int SCREEN_HEIGHT     = 480
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [2:0]                          zoom_in,
    input  logic signed [ENGINE_DATA_WIDTH-1:0] x_offset_in,
    input  logic signed [ENGINE_DATA_WIDTH-1:0] y_offset_in,
    input  logic [NUM_ENGINES-1:0]              engine_ready,
    input  logic [NUM_ENGINES-1:0]              engine_idle,
    output logic [NUM_ENGINES-1:0]              dispatch,
    output logic [PIXEL_DATA_WIDTH-1:0]         x0_,
    output logic [PIXEL_DATA_WIDTH-1:0]         y0_,
    output logic [2:0]                          zoom,
    output logic signed [ENGINE_DATA_WIDTH-1:0] x_offset,
    output logic signed [ENGINE_DATA_WIDTH-1:0] y_offset,
    output logic                                busy,
    output logic                                frame_done
);
    localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam int CW    = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST = PIXEL_DATA_WIDTH'(SCREEN_WIDTH - 1);
    localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST = PIXEL_DATA_WIDTH'(SCREEN_HEIGHT - 1);
    localparam logic [PIXEL_DATA_WIDTH-1:0] PX_ONE = PIXEL_DATA_WIDTH'(1);
    localparam logic [PTR_W-1:0]            PTR_LAST = PTR_W'(NUM_ENGINES - 1);
    localparam logic [PTR_W-1:0]            PTR_ONE  = PTR_W'(1);
    localparam logic [CW-1:0]               CAND_N   = CW'(NUM_ENGINES);

    logic [1:0]                  state;
    logic [PIXEL_DATA_WIDTH-1:0] x_cnt;
    logic [PIXEL_DATA_WIDTH-1:0] y_cnt;
    logic [PTR_W-1:0]            ptr;
    logic [PTR_W-1:0]            grant_idx;
    logic [NUM_ENGINES-1:0]      mask;
    logic [NUM_ENGINES-1:0]      eligible;
    logic [NUM_ENGINES-1:0]      grant;
    logic [CW-1:0]               cand;
    logic                        grant_found;
    logic                        drain_first;
    logic                        last_pixel;

    // mask blocks the engine granted last cycle while its ready is still falling
    assign eligible   = engine_ready & ~mask;
    assign last_pixel = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        grant       = '0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            cand = {1'b0, ptr} + CW'(k);
            if (cand >= CAND_N) begin
                cand = cand - CAND_N;
            end
            if (!grant_found && eligible[cand[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[PTR_W-1:0];
            end
        end
        if (grant_found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            x_cnt       <= '0;
            y_cnt       <= '0;
            ptr         <= '0;
            mask        <= '0;
            drain_first <= 1'b0;
            dispatch    <= '0;
            x0_         <= '0;
            y0_         <= '0;
            zoom        <= '0;
            x_offset    <= '0;
            y_offset    <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            dispatch   <= '0;
            mask       <= '0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        zoom     <= zoom_in;
                        x_offset <= x_offset_in;
                        y_offset <= y_offset_in;
                        x_cnt    <= '0;
                        y_cnt    <= '0;
                        busy     <= 1'b1;
                        state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (grant_found) begin
                        dispatch <= grant;
                        mask     <= grant;
                        x0_      <= x_cnt;
                        y0_      <= y_cnt;
                        ptr      <= (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_ONE;
                        if (x_cnt == X_LAST) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + PX_ONE;
                        end else begin
                            x_cnt <= x_cnt + PX_ONE;
                        end
                        if (last_pixel) begin
                            state       <= S_DRAIN;
                            drain_first <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // engines have not yet seen the final dispatch in the first DRAIN cycle
                    if (drain_first) begin
                        drain_first <= 1'b0;
                    end else if (&engine_idle) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
`ifndef CONTINUOUS_FRAME_EN
                        busy       <= 1'b0;
`endif
                    end
                end
                S_DONE: begin
`ifdef CONTINUOUS_FRAME_EN
                    zoom     <= zoom_in;
                    x_offset <= x_offset_in;
                    y_offset <= y_offset_in;
                    x_cnt    <= '0;
                    y_cnt    <= '0;
                    state    <= S_SCAN;
`else
                    state    <= S_IDLE;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_scheduler.sv
// tb/tb_pixel_scheduler.sv - scoreboard bench for pixel_scheduler on a 2-engine 4x2 screen
module tb_pixel_scheduler;
    localparam int NE = 2;
    localparam int PW = 10;
    localparam int EW = 25;
    localparam int SW = 4;
    localparam int SH = 2;
    localparam logic signed [EW-1:0] XOFF = -25'sh100000;
    localparam logic signed [EW-1:0] YOFF = 25'sh00abcd;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 start = 1'b0;
    logic [2:0]           zoom_in = 3'd0;
    logic signed [EW-1:0] x_offset_in = '0;
    logic signed [EW-1:0] y_offset_in = '0;
    logic [NE-1:0]        engine_ready = '0;
    logic [NE-1:0]        engine_idle = '0;
    logic [NE-1:0]        dispatch;
    logic [PW-1:0]        x0_;
    logic [PW-1:0]        y0_;
    logic [2:0]           zoom;
    logic signed [EW-1:0] x_offset;
    logic signed [EW-1:0] y_offset;
    logic                 busy;
    logic                 frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int eng;
        int x;
        int y;
    } exp_t;
    exp_t sb[$];

    pixel_scheduler #(
        .NUM_ENGINES(NE),
        .PIXEL_DATA_WIDTH(PW),
        .ENGINE_DATA_WIDTH(EW),
        .SCREEN_WIDTH(SW),
        .SCREEN_HEIGHT(SH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .zoom_in(zoom_in),
        .x_offset_in(x_offset_in),
        .y_offset_in(y_offset_in),
        .engine_ready(engine_ready),
        .engine_idle(engine_idle),
        .dispatch(dispatch),
        .x0_(x0_),
        .y0_(y0_),
        .zoom(zoom),
        .x_offset(x_offset),
        .y_offset(y_offset),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // mode 0: all engines ready, grants alternate; mode 1: only engine 0 ready
    task automatic push_frame(input int mode);
        exp_t e;
        for (int y = 0; y < SH; y++) begin
            for (int x = 0; x < SW; x++) begin
                e.eng = (mode == 0) ? ((y * SW + x) % NE) : 0;
                e.x   = x;
                e.y   = y;
                sb.push_back(e);
            end
        end
    endtask

    task automatic do_reset;
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dispatch !== '0 || x0_ !== '0 || y0_ !== '0) begin
            errors++;
            $display("FAIL reset_pixel: dispatch=%b x=%0d y=%0d expected all 0", dispatch, x0_, y0_);
        end
        checks++;
        if (zoom !== 3'd0 || x_offset !== '0 || y_offset !== '0) begin
            errors++;
            $display("FAIL reset_config: zoom=%0d xo=%0d yo=%0d expected all 0", zoom, x_offset, y_offset);
        end
        checks++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: busy=%b frame_done=%b expected 0 0", busy, frame_done);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_all_ready;
        int n = 0, first = -1, last = -1, fd_at = -1, cfg_bad = 0;
        exp_t e;
        engine_ready = '1;
        engine_idle  = '1;
        zoom_in      = 3'd3;
        x_offset_in  = XOFF;
        y_offset_in  = YOFF;
        push_frame(0);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || zoom !== 3'd3 || x_offset !== XOFF || y_offset !== YOFF) begin
            errors++;
            $display("FAIL start_latch: busy=%b zoom=%0d xo=%0d yo=%0d expected 1 3 %0d %0d",
                     busy, zoom, x_offset, y_offset, XOFF, YOFF);
        end
        for (int cyc = 0; cyc < 40 && fd_at < 0; cyc++) begin
            @(negedge clk);
            if (dispatch !== '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL all_ready_extra: dispatch=%b x=%0d y=%0d expected none", dispatch, x0_, y0_);
                end else begin
                    e = sb.pop_front();
                    if (dispatch !== (NE'(1) << e.eng) || x0_ !== PW'(e.x) || y0_ !== PW'(e.y)) begin
                        errors++;
                        $display("FAIL all_ready_pixel: dispatch=%b (%0d,%0d) expected eng %0d (%0d,%0d)",
                                 dispatch, x0_, y0_, e.eng, e.x, e.y);
                    end
                end
                if (first < 0) first = cyc;
                last = cyc;
                n++;
                if (n == 2) begin
                    zoom_in     = 3'd5;
                    x_offset_in = 25'sh001234;
                    y_offset_in = 25'sh000777;
                end
            end
            if (zoom !== 3'd3 || x_offset !== XOFF || y_offset !== YOFF) cfg_bad++;
            if (frame_done === 1'b1) fd_at = cyc;
        end
        checks++;
        if (n != SW * SH || sb.size() != 0) begin
            errors++;
            $display("FAIL all_ready_count: dispatches=%0d left=%0d expected %0d 0", n, sb.size(), SW * SH);
        end
        checks++;
        if (last - first != SW * SH - 1) begin
            errors++;
            $display("FAIL all_ready_span: span=%0d expected %0d", last - first, SW * SH - 1);
        end
        checks++;
        if (cfg_bad != 0) begin
            errors++;
            $display("FAIL config_hold: changed cycles=%0d expected 0", cfg_bad);
        end
        checks++;
        if (fd_at < 0 || fd_at - last != 2) begin
            errors++;
            $display("FAIL done_latency: frame_done at %0d, last dispatch at %0d, expected distance 2", fd_at, last);
        end
`ifndef CONTINUOUS_FRAME_EN
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL done_busy: busy=%b expected 0", busy);
        end
`endif
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: frame_done=%b expected 0", frame_done);
        end
    endtask

    task automatic test_single_ready;
        int n = 0, first = -1, last = -1, prev = -10, b2b = 0, fd_at = -1;
        exp_t e;
        do_reset();
        engine_ready = 2'b01;
        engine_idle  = '1;
        push_frame(1);
        pulse_start();
        checks++;
        if (zoom !== 3'd5 || x_offset !== 25'sh001234) begin
            errors++;
            $display("FAIL relatch: zoom=%0d xo=%0d expected 5 %0d", zoom, x_offset, 25'sh001234);
        end
        for (int cyc = 0; cyc < 40 && fd_at < 0; cyc++) begin
            @(negedge clk);
            if (dispatch !== '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL single_extra: dispatch=%b expected none", dispatch);
                end else begin
                    e = sb.pop_front();
                    if (dispatch !== (NE'(1) << e.eng) || x0_ !== PW'(e.x) || y0_ !== PW'(e.y)) begin
                        errors++;
                        $display("FAIL single_pixel: dispatch=%b (%0d,%0d) expected eng %0d (%0d,%0d)",
                                 dispatch, x0_, y0_, e.eng, e.x, e.y);
                    end
                end
                if (cyc - prev < 2) b2b++;
                prev = cyc;
                if (first < 0) first = cyc;
                last = cyc;
                n++;
            end
            if (frame_done === 1'b1) fd_at = cyc;
        end
        checks++;
        if (n != SW * SH || last - first != 2 * (SW * SH - 1) || b2b != 0) begin
            errors++;
            $display("FAIL single_timing: n=%0d span=%0d b2b=%0d expected %0d %0d 0",
                     n, last - first, b2b, SW * SH, 2 * (SW * SH - 1));
        end
        checks++;
        if (fd_at < 0) begin
            errors++;
            $display("FAIL single_done: frame_done seen=0 expected 1");
        end
    endtask

    task automatic test_drain_hold;
        int n = 0, bad = 0;
        exp_t e;
        do_reset();
        engine_ready = '1;
        engine_idle  = '1;
        push_frame(0);
        pulse_start();
        for (int cyc = 0; cyc < 30 && n < SW * SH; cyc++) begin
            @(negedge clk);
            if (dispatch !== '0) begin
                checks++;
                e = sb.pop_front();
                if (x0_ !== PW'(e.x) || y0_ !== PW'(e.y)) begin
                    errors++;
                    $display("FAIL drain_pixel: (%0d,%0d) expected (%0d,%0d)", x0_, y0_, e.x, e.y);
                end
                n++;
            end
        end
        checks++;
        if (n != SW * SH) begin
            errors++;
            $display("FAIL drain_count: dispatches=%0d expected %0d", n, SW * SH);
        end
        engine_idle = 2'b01;
        repeat (10) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || busy !== 1'b1 || dispatch !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL drain_hold: bad cycles=%0d expected 0", bad);
        end
        engine_idle = 2'b11;
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL drain_release: frame_done=%b expected 1", frame_done);
        end
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL drain_pulse: frame_done=%b expected 0", frame_done);
        end
    endtask

    task automatic test_reset_mid;
        int n = 0, bad = 0, fd = 0;
        exp_t e;
        do_reset();
        engine_ready = '1;
        engine_idle  = '1;
        zoom_in      = 3'd3;
        x_offset_in  = XOFF;
        push_frame(0);
        pulse_start();
        for (int cyc = 0; cyc < 20 && n < 3; cyc++) begin
            @(negedge clk);
            if (dispatch !== '0) begin
                e = sb.pop_front();
                n++;
            end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (dispatch !== '0 || x0_ !== '0 || y0_ !== '0 || zoom !== '0 || x_offset !== '0 ||
            y_offset !== '0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: d=%b x=%0d y=%0d z=%0d xo=%0d yo=%0d busy=%b fd=%b expected all 0",
                     dispatch, x0_, y0_, zoom, x_offset, y_offset, busy, frame_done);
        end
        reset = 1'b1;
        sb.delete();
        repeat (10) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || dispatch !== '0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mid_abandon: active cycles=%0d expected 0", bad);
        end
        zoom_in = 3'd1;
        push_frame(0);
        pulse_start();
        n = 0;
        for (int cyc = 0; cyc < 40 && fd == 0; cyc++) begin
            @(negedge clk);
            if (dispatch !== '0) begin
                checks++;
                e = sb.pop_front();
                if (dispatch !== (NE'(1) << e.eng) || x0_ !== PW'(e.x) || y0_ !== PW'(e.y)) begin
                    errors++;
                    $display("FAIL restart_pixel: dispatch=%b (%0d,%0d) expected eng %0d (%0d,%0d)",
                             dispatch, x0_, y0_, e.eng, e.x, e.y);
                end
                n++;
            end
            if (frame_done === 1'b1) fd = 1;
        end
        checks++;
        if (n != SW * SH || fd != 1 || zoom !== 3'd1) begin
            errors++;
            $display("FAIL restart_frame: n=%0d done=%0d zoom=%0d expected %0d 1 1", n, fd, zoom, SW * SH);
        end
    endtask

`ifdef CONTINUOUS_FRAME_EN
    task automatic test_continuous;
        int n = 0, fd = 0, idle_busy = 0;
        exp_t e;
        do_reset();
        engine_ready = '1;
        engine_idle  = '1;
        zoom_in      = 3'd2;
        push_frame(0);
        push_frame(0);
        pulse_start();
        for (int cyc = 0; cyc < 80 && fd < 2; cyc++) begin
            @(negedge clk);
            if (dispatch !== '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL cont_extra: dispatch=%b expected none", dispatch);
                end else begin
                    e = sb.pop_front();
                    if (dispatch !== (NE'(1) << e.eng) || x0_ !== PW'(e.x) || y0_ !== PW'(e.y)) begin
                        errors++;
                        $display("FAIL cont_pixel: dispatch=%b (%0d,%0d) expected eng %0d (%0d,%0d)",
                                 dispatch, x0_, y0_, e.eng, e.x, e.y);
                    end
                end
                n++;
            end
            if (busy !== 1'b1) idle_busy++;
            if (frame_done === 1'b1) begin
                fd++;
                if (fd == 1) zoom_in = 3'd6;
            end
        end
        checks++;
        if (n != 2 * SW * SH || fd != 2 || zoom !== 3'd6 || idle_busy != 0) begin
            errors++;
            $display("FAIL cont_frames: n=%0d done=%0d zoom=%0d busy_low=%0d expected %0d 2 6 0",
                     n, fd, zoom, idle_busy, 2 * SW * SH);
        end
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_all_ready();
        test_single_ready();
        test_drain_hold();
        test_reset_mid();
`ifdef CONTINUOUS_FRAME_EN
        test_continuous();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
